// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: funct3 codes, FSM states, byte-lane select.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // funct3[1:0] gives the access size; sub-size offsets are forced to natural alignment
  function automatic logic [3:0] byte_sel(input logic [2:0] funct3, input logic [1:0] a);
    case (funct3[1:0])
      2'b00:   byte_sel = 4'b0001 << a;
      2'b01:   byte_sel = 4'b0011 << {a[1], 1'b0};
      default: byte_sel = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-data lane extraction with sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] dat_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] dat_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = dat_i[{lane_i, 3'b000} +: 8];
    h = lane_i[1] ? dat_i[31:16] : dat_i[15:0];
    case (funct3_i)
      F3_LB:   dat_o = {{24{b[7]}}, b};
      F3_LH:   dat_o = {{16{h[15]}}, h};
      F3_LW:   dat_o = dat_i;
      F3_LBU:  dat_o = {24'd0, b};
      F3_LHU:  dat_o = {16'd0, h};
      default: dat_o = dat_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one Wishbone classic cycle per load/store, stalling the pipeline meanwhile.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32  // four byte lanes; no other width is supported
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] memory_data_out,
  output logic                  misalign_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  mem_state_t state_q, state_d;

  logic                  req, start, ack_done, squash_now, bad_align;
  logic                  cyc_q, cyc_d, we_q, we_d, squash_q, squash_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d, rdata_q, rdata_d, aligned;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            lane_q, lane_d, lane_req;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign bad_align = ((funct3[1:0] == 2'b01) && addr_in[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  assign req        = (mem_read | mem_write) & ~flush;
  assign squash_now = squash_q | flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = bad_align ? DONE : BUSY;
      BUSY:    if (wb_ack_i) state_d = squash_now ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    start     = 1'b0;
    ack_done  = 1'b0;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        stall_req = req;
        start     = req & ~bad_align;
      end
      BUSY: begin
        stall_req = 1'b1;
        ack_done  = wb_ack_i;
      end
      default: ;
    endcase

    case (funct3[1:0])
      2'b00:   lane_req = addr_in[1:0];
      2'b01:   lane_req = {addr_in[1], 1'b0};
      default: lane_req = 2'b00;
    endcase

    if (start) begin
      cyc_d  = 1'b1;
      we_d   = mem_write;
      adr_d  = {addr_in[ADDR_WIDTH-1:2], 2'b00};
      sel_d  = byte_sel(funct3, addr_in[1:0]);
      f3_d   = funct3;
      lane_d = lane_req;
      case (funct3[1:0])
        2'b00:   wdat_d = {4{store_data[7:0]}};
        2'b01:   wdat_d = {2{store_data[15:0]}};
        default: wdat_d = store_data;
      endcase
    end

    // a squashed cycle still completes on the bus, but its data never reaches the pipeline
    squash_d = (state_q == BUSY) ? (~wb_ack_i & squash_now) : 1'b0;
    if (ack_done) begin
      cyc_d = 1'b0;
      if (!we_q && !squash_now) rdata_d = aligned;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = (state_q == IDLE) && req && bad_align;
`endif
  end

  load_align u_load_align (
    .dat_i    (wb_dat_i),
    .funct3_i (f3_q),
    .lane_i   (lane_q),
    .dat_o    (aligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= 4'd0;
      wdat_q   <= '0;
      f3_q     <= 3'd0;
      lane_q   <= 2'd0;
      squash_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      wdat_q   <= wdat_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      squash_q <= squash_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_q <= 1'b0;
    else          misalign_q <= misalign_d;
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign wb_cyc_o        = cyc_q;
  assign wb_stb_o        = cyc_q;
  assign wb_we_o         = we_q;
  assign wb_adr_o        = adr_q;
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = wdat_q;
  assign memory_data_out = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed accesses against a size/offset arithmetic model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0, wb_ack_i = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr_in = '0, store_data = '0, wb_dat_i = '0;
  logic        stall_req, misalign_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] memory_data_out, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr_in(addr_in), .store_data(store_data), .flush(flush),
    .stall_req(stall_req), .memory_data_out(memory_data_out), .misalign_o(misalign_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_starts = 0;
  logic [31:0] exp_mdo = '0, exp_adr = '0, exp_wdat = '0;
  logic [3:0]  exp_sel = '0;
  logic        exp_we = 1'b0, prev_cyc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Model: access size in bytes and its naturally aligned byte offset
  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic int off(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) / sz(f3)) * sz(f3);
  endfunction
  function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) if (i >= off(f3, a) && i < off(f3, a) + sz(f3)) s[i] = 1'b1;
    return s;
  endfunction
  function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz(f3)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int s = sz(f3);
    logic [31:0] v, mask;
    v = d >> (8 * off(f3, a));
    if (s < 4) begin
      mask = (32'd1 << (8 * s)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*s-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Per-cycle comparison of registered outputs against the model state
  always @(posedge clk) begin
    #4;
    if (reset_n) begin
      chk("mdo", memory_data_out, exp_mdo);
      chk("stb_vs_cyc", {31'd0, wb_stb_o}, {31'd0, wb_cyc_o});
      if (wb_cyc_o) begin
        chk("adr", wb_adr_o, exp_adr);
        chk("sel", {28'd0, wb_sel_o}, {28'd0, exp_sel});
        chk("we", {31'd0, wb_we_o}, {31'd0, exp_we});
        if (exp_we) chk("dat_o", wb_dat_o, exp_wdat);
      end
`ifndef MEM_MISALIGN_TRAP_EN
      chk("misalign_tied", {31'd0, misalign_o}, 32'd0);
`endif
    end
    if (wb_cyc_o && !prev_cyc) n_starts++;
    prev_cyc = wb_cyc_o;
  end

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int waits, input logic [31:0] rdat,
                        output int stalls, output logic [3:0] o_sel, output logic [31:0] o_dat,
                        output logic [31:0] o_adr, output logic o_we, output logic o_mis);
    int  busy_n = 0;
    bit  done = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr_in = a; store_data = sd;
    exp_adr = {a[31:2], 2'b00}; exp_sel = m_sel(f3, a); exp_we = wr; exp_wdat = m_wdat(f3, sd);
    stalls = 0; o_sel = '0; o_dat = '0; o_adr = '0; o_we = 1'b0; o_mis = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!stall_req) begin done = 1; break; end
      stalls++;
      if (wb_cyc_o) begin
        o_sel = wb_sel_o; o_dat = wb_dat_o; o_adr = wb_adr_o; o_we = wb_we_o;
        if (busy_n == waits) begin
          wb_ack_i = 1'b1; wb_dat_i = rdat;
          if (rd) exp_mdo = m_load(f3, a, rdat);
        end
        busy_n++;
      end
      @(negedge clk);
      wb_ack_i = 1'b0; wb_dat_i = $urandom;
    end
    if (!done) chk("stall_timeout", 32'd1, 32'd0);
    o_mis = misalign_o;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  int st, starts0;
  logic [3:0]  s_sel;
  logic [31:0] s_dat, s_adr;
  logic        s_we, s_mis;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_mdo", memory_data_out, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // LW, ack in first BUSY cycle
    starts0 = n_starts;
    access(1, 0, 3'b010, 32'h8000_0104, 0, 0, 32'hDEADBEEF, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("lw_stalls", st, 2);
    chk("lw_sel", {28'd0, s_sel}, 32'h0000_000F);
    chk("lw_adr", s_adr, 32'h8000_0104);
    chk("lw_mdo", memory_data_out, 32'hDEADBEEF);
    chk("lw_single_issue", n_starts - starts0, 1);

    access(1, 0, 3'b000, 32'h8000_0103, 0, 1, 32'h80AA_BBCC, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("lb_mdo", memory_data_out, 32'hFFFF_FF80);
    chk("lb_sel", {28'd0, s_sel}, 32'h0000_0008);
    chk("lb_stalls", st, 3);
    access(1, 0, 3'b100, 32'h8000_0103, 0, 0, 32'h80AA_BBCC, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("lbu_mdo", memory_data_out, 32'h0000_0080);
    access(1, 0, 3'b001, 32'h8000_0102, 0, 0, 32'h8001_1234, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("lh_mdo", memory_data_out, 32'hFFFF_8001);
    chk("lh_sel", {28'd0, s_sel}, 32'h0000_000C);
    access(1, 0, 3'b101, 32'h8000_0100, 0, 2, 32'h1234_F00D, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("lhu_mdo", memory_data_out, 32'h0000_F00D);

    // SB with three wait states; load result must be held across stores
    starts0 = n_starts;
    access(0, 1, 3'b000, 32'h8000_0101, 32'h1234_5678, 3, 32'hFFFF_FFFF, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("sb_stalls", st, 5);
    chk("sb_sel", {28'd0, s_sel}, 32'h0000_0002);
    chk("sb_dat", s_dat, 32'h7878_7878);
    chk("sb_we", {31'd0, s_we}, 32'd1);
    chk("sb_mdo_held", memory_data_out, 32'h0000_F00D);
    chk("sb_single_issue", n_starts - starts0, 1);
    access(0, 1, 3'b001, 32'h8000_0202, 32'hAAAA_5678, 0, 0, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("sh_dat", s_dat, 32'h5678_5678);
    chk("sh_sel", {28'd0, s_sel}, 32'h0000_000C);
    access(0, 1, 3'b010, 32'h8000_0300, 32'hCAFE_BABE, 1, 0, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("sw_dat", s_dat, 32'hCAFE_BABE);

    // Flush in first BUSY cycle: cycle runs to ack, no data, no DONE
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr_in = 32'h8000_0400;
    exp_adr = 32'h8000_0400; exp_sel = 4'hF; exp_we = 1'b0;
    #1 chk("fl_idle_stall", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    #1 chk("fl_busy_cyc", {31'd0, wb_cyc_o}, 32'd1);
    flush = 1'b1; mem_read = 1'b0;
    @(negedge clk); flush = 1'b0;
    #1 chk("fl_hold1", {31'd0, wb_cyc_o}, 32'd1);
    chk("fl_stall1", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    #1 chk("fl_hold2", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    @(negedge clk); wb_ack_i = 1'b0;
    mem_read = 1'b1; funct3 = 3'b010; addr_in = 32'h8000_0500; exp_adr = 32'h8000_0500;
    #1 chk("fl_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk("fl_no_done", {31'd0, stall_req}, 32'd1);
    chk("fl_mdo_kept", memory_data_out, 32'h0000_F00D);
    @(negedge clk);
    #1 chk("fl_next_cyc", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BAD_F00D; exp_mdo = 32'h0BAD_F00D;
    @(negedge clk); wb_ack_i = 1'b0;
    #1 chk("fl_next_done", {31'd0, stall_req}, 32'd0);
    mem_read = 1'b0;

    // Ack while idle is ignored
    @(negedge clk); wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
    @(negedge clk);
    #1 chk("idle_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("idle_ack_stall", {31'd0, stall_req}, 32'd0);
    wb_ack_i = 1'b0;

    // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
    starts0 = n_starts;
    access(1, 0, 3'b010, 32'h8000_0102, 0, 0, 32'h7777_7777, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("mis_stalls", st, 1);
    chk("mis_pulse", {31'd0, s_mis}, 32'd1);
    chk("mis_no_cyc", n_starts - starts0, 0);
    @(negedge clk);
    #1 chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
`else
    access(1, 0, 3'b010, 32'h8000_0102, 0, 0, 32'h7777_1234, st, s_sel, s_dat, s_adr, s_we, s_mis);
    chk("mis_adr", s_adr, 32'h8000_0100);
    chk("mis_sel", {28'd0, s_sel}, 32'h0000_000F);
    chk("mis_mdo", memory_data_out, 32'h7777_1234);
    chk("mis_stalls", st, 2);
`endif

    // Reset while BUSY drops the bus at once; stale ack afterwards has no effect
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr_in = 32'h8000_0600; exp_adr = 32'h8000_0600;
    exp_sel = 4'hF; exp_we = 1'b0;
    @(negedge clk);
    #1 chk("rb_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    reset_n = 1'b0; mem_read = 1'b0; exp_mdo = '0;
    #1 chk("rb_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rb_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rb_mdo", memory_data_out, 32'd0);
    @(negedge clk); reset_n = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
    @(negedge clk); wb_ack_i = 1'b0;
    #1 chk("rb_idle_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rb_idle_stall", {31'd0, stall_req}, 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
